// File: rtl/my_micro_sequencer.sv
// my_micro_sequencer: micro-PC with fetch/dispatch/seq/jump sequencing, illegal/overflow/watchdog trap.
// Optional USEQ_PERF_EN adds retired-instruction and RUN-cycle counters.
module my_micro_sequencer #(
  parameter int                  UADDR_W    = 8,
  parameter logic [UADDR_W-1:0]  FETCH_ADDR = 8'h00,
  parameter logic [UADDR_W-1:0]  TRAP_ADDR  = 8'hFF,
  parameter int                  MAX_USTEPS = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_ctl,
  input  logic [UADDR_W-1:0] i_dispatch_addr,
  input  logic               i_dispatch_valid,
  input  logic [UADDR_W-1:0] i_jump_addr,
  input  logic               i_stall,
`ifdef USEQ_PERF_EN
  output logic [31:0]        o_instr_cnt,
  output logic [31:0]        o_cycle_cnt,
`endif
  output logic [UADDR_W-1:0] o_upc,
  output logic               o_fetch,
  output logic               o_instr_done,
  output logic               o_illegal,
  output logic [1:0]         o_trap_cause
);
  typedef enum logic {RUN, TRAP} state_e;
  localparam logic [1:0] CTL_FETCH = 2'b00, CTL_DISP = 2'b01, CTL_SEQ = 2'b10;
  localparam logic [7:0] MAX_C = 8'(MAX_USTEPS);
  state_e             state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [1:0]         cause_q, cause_d, trap_c;
  // Trap priority: illegal dispatch, then SEQ overflow, then watchdog
  assign trap_c = (i_ctl == CTL_DISP && !i_dispatch_valid) ? 2'b01 :
                  (i_ctl == CTL_SEQ && &upc_q)              ? 2'b11 :
                  (cnt_q == MAX_C)                          ? 2'b10 : 2'b00;
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    cause_d = cause_q;
    if (state_q == RUN && !i_stall) begin
      if (i_ctl == CTL_FETCH) begin
        upc_d  = FETCH_ADDR;
        cnt_d  = 8'd0;
        done_d = 1'b1;
      end else if (trap_c != 2'b00) begin
        state_d = TRAP;
        upc_d   = TRAP_ADDR;
        cause_d = trap_c;
      end else begin
        upc_d = (i_ctl == CTL_DISP) ? i_dispatch_addr :
                (i_ctl == CTL_SEQ)  ? upc_q + UADDR_W'(1) : i_jump_addr;
        cnt_d = cnt_q + 8'd1;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      upc_q   <= FETCH_ADDR;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end
`ifdef USEQ_PERF_EN
  logic [31:0] icnt_q, ccnt_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      icnt_q <= 32'd0;
      ccnt_q <= 32'd0;
    end else if (state_q == RUN) begin
      ccnt_q <= ccnt_q + 32'd1;
      icnt_q <= icnt_q + {31'd0, done_d};
    end
  end
  assign o_instr_cnt = icnt_q;
  assign o_cycle_cnt = ccnt_q;
`endif
  assign o_upc        = upc_q;
  assign o_fetch      = state_q == RUN && upc_q == FETCH_ADDR;
  assign o_instr_done = done_q;
  assign o_illegal    = state_q == TRAP;
  assign o_trap_cause = cause_q;
endmodule

// File: tb/tb_my_micro_sequencer.sv
// tb_my_micro_sequencer: directed spec scenarios plus random stimulus, scoreboarded against a reference model.
module tb_my_micro_sequencer;
  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [1:0] i_ctl = 2'b00;
  logic [7:0] i_dispatch_addr = 8'h00, i_jump_addr = 8'h00;
  logic       i_dispatch_valid = 1'b1, i_stall = 1'b0;
  logic [7:0] o_upc;
  logic       o_fetch, o_instr_done, o_illegal;
  logic [1:0] o_trap_cause;
`ifdef USEQ_PERF_EN
  logic [31:0] o_instr_cnt, o_cycle_cnt;
`endif
  always #5 clk = ~clk;

  my_micro_sequencer dut (
    .i_clk(clk), .i_rst(i_rst), .i_ctl(i_ctl), .i_dispatch_addr(i_dispatch_addr),
    .i_dispatch_valid(i_dispatch_valid), .i_jump_addr(i_jump_addr), .i_stall(i_stall),
`ifdef USEQ_PERF_EN
    .o_instr_cnt(o_instr_cnt), .o_cycle_cnt(o_cycle_cnt),
`endif
    .o_upc(o_upc), .o_fetch(o_fetch), .o_instr_done(o_instr_done),
    .o_illegal(o_illegal), .o_trap_cause(o_trap_cause)
  );

  typedef struct {
    int upc; bit fetch; bit done; bit ill; int cause; int ic; int cc;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  int m_upc = 0, m_cause = 0, m_steps = 0, m_ic = 0, m_cc = 0;
  bit m_trap = 0, m_done = 0;

  task automatic model(input int c, input int da, input bit dv, input int ja, input bit st, input bit r);
    int tc;
    if (r) begin
      m_upc = 0; m_trap = 0; m_cause = 0; m_steps = 0; m_done = 0; m_ic = 0; m_cc = 0;
    end else if (m_trap) m_done = 0;
    else begin
      m_cc++;
      m_done = 0;
      if (!st) begin
        if (c == 0) begin
          m_upc = 0; m_steps = 0; m_done = 1; m_ic++;
        end else begin
          tc = 0;
          if (c == 1 && !dv) tc = 1;
          else if (c == 2 && m_upc == 255) tc = 3;
          else if (m_steps + 1 > 15) tc = 2;
          if (tc != 0) begin
            m_trap = 1; m_cause = tc; m_upc = 255;
          end else begin
            m_upc = (c == 1) ? da : (c == 2) ? (m_upc + 1) % 256 : ja;
            m_steps++;
          end
        end
      end
    end
  endtask

  task automatic step(input logic [1:0] c, input logic [7:0] da, input logic dv,
                      input logic [7:0] ja, input logic st, input logic r);
    exp_t e;
    @(negedge clk);
    i_ctl = c; i_dispatch_addr = da; i_dispatch_valid = dv; i_jump_addr = ja; i_stall = st; i_rst = r;
    model(c, da, dv, ja, st, r);
    e.upc = m_upc; e.fetch = !m_trap && m_upc == 0; e.done = m_done; e.ill = m_trap;
    e.cause = m_cause; e.ic = m_ic; e.cc = m_cc;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("upc", o_upc, e.upc);
      chk("fetch", o_fetch, e.fetch);
      chk("instr_done", o_instr_done, e.done);
      chk("illegal", o_illegal, e.ill);
      chk("trap_cause", o_trap_cause, e.cause);
`ifdef USEQ_PERF_EN
      chk("instr_cnt", o_instr_cnt, e.ic);
      chk("cycle_cnt", o_cycle_cnt, e.cc);
`endif
    end
  end

  initial begin
    step(2'b00, 8'h00, 1, 8'h00, 0, 1);
    step(2'b00, 8'h00, 1, 8'h00, 0, 1);
    step(2'b10, 8'h00, 1, 8'h00, 0, 0);
    step(2'b01, 8'h10, 1, 8'h00, 0, 0);
    step(2'b00, 8'h00, 1, 8'h00, 0, 0);
    step(2'b10, 8'h00, 1, 8'h00, 0, 0);
    repeat (3) step(2'b01, 8'h10, 1, 8'h00, 1, 0);
    step(2'b01, 8'h10, 1, 8'h00, 0, 0);
    step(2'b01, 8'h33, 0, 8'h00, 0, 0);
    step(2'b00, 8'h00, 1, 8'h00, 0, 0);
    step(2'b10, 8'h00, 1, 8'h00, 0, 0);
    step(2'b11, 8'h00, 1, 8'h44, 0, 0);
    step(2'b00, 8'h00, 1, 8'h00, 0, 1);
    step(2'b11, 8'h00, 1, 8'h20, 0, 0);
    repeat (15) step(2'b10, 8'h00, 1, 8'h00, 0, 0);
    step(2'b00, 8'h00, 1, 8'h00, 0, 1);
    step(2'b11, 8'h00, 1, 8'hFE, 0, 0);
    step(2'b10, 8'h00, 1, 8'h00, 0, 0);
    step(2'b10, 8'h00, 1, 8'h00, 0, 0);
    step(2'b10, 8'h00, 1, 8'h00, 0, 1);
    repeat (3) begin
      step(2'b01, 8'h40, 1, 8'h00, 0, 0);
      step(2'b10, 8'h00, 1, 8'h00, 1, 0);
      step(2'b10, 8'h00, 1, 8'h00, 0, 0);
      step(2'b00, 8'h00, 1, 8'h00, 0, 0);
    end
    for (int n = 0; n < 3000; n++)
      step(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 29) != 0,
           8'($urandom_range(0, 3) == 0 ? 8'hFE : 8'($urandom)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
